// File: rtl/cpu_types_pkg.sv
// Shared CPU types: BTB direction-counter encodings and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_types_pkg;

    // 2-bit direction counter encodings; bit 1 is the taken prediction.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

endpackage

// File: rtl/pc_predict_if.sv
// Bundle of the fetch-PC predictor signals with per-agent views.
// Latency: n/a (wiring only).
// Backpressure: pcEN from the hazard unit stalls the PC; redirects bypass it.
interface pc_predict_if #(
    parameter int PC_W = 32
) (
    input logic CLK,
    input logic nRST
);
    logic            pcEN;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic [PC_W-1:0] imemaddr;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;

    // The predictor itself.
    modport pc (
        input  CLK, nRST, pcEN, redir_valid, redir_pc,
               upd_valid, upd_pc, upd_taken, upd_target,
        output imemaddr, pred_taken, pred_target
    );

    // Hazard unit only gates advancement.
    modport hazard (
        output pcEN
    );

    // Execute stage resolves branches: redirects and BTB training.
    modport exec (
        output redir_valid, redir_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_taken, pred_target
    );
endinterface

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter next-value: +1 on taken, -1 on not taken.
// Latency: combinational.
// Backpressure: none.
module sat_ctr2
    import cpu_types_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step toward the observed direction, sticking at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i && (ctr_i != CTR_STRONG_T)) begin
            ctr_o = ctr_i + 2'd1;
        end else if (!taken_i && (ctr_i != CTR_STRONG_NT)) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with direct-mapped BTB and 2-bit direction counters.
// Latency: redirect/update visible 1 cycle after the edge; lookup is combinational.
// Backpressure: pcEN=0 holds the PC, but redirects and BTB updates still apply.
module pc_predict
    import cpu_types_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] PC_INIT     = '0,
    parameter int              BTB_ENTRIES = 16,
    localparam int             IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            pcEN,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic [PC_W-1:0] imemaddr,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target
);

    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t      btb_q [BTB_ENTRIES];
    logic [PC_W-1:0] pc_q, pc_d;

    // Lookup side (current fetch PC).
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    btb_entry_t       rd_e;
    logic             rd_hit;

    // Update side (resolved instruction PC).
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    btb_entry_t       up_e;
    logic             up_hit;
    logic [1:0]       up_ctr_nxt;
    logic             wr_en;
    btb_entry_t       wr_e;

    // Byte-offset bits never select an entry.
    logic [1:0] unused_upd_lsb;
    assign unused_upd_lsb = upd_pc[1:0];

    assign imemaddr = pc_q;

    assign rd_idx = pc_q[IDX_W+1:2];
    assign rd_tag = pc_q[PC_W-1:IDX_W+2];
    assign rd_e   = btb_q[rd_idx];
    assign rd_hit = rd_e.valid && (rd_e.tag == rd_tag);

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[PC_W-1:IDX_W+2];
    assign up_e   = btb_q[up_idx];
    assign up_hit = up_e.valid && (up_e.tag == up_tag);

    // Prediction reads the array before any same-cycle write lands.
    always_comb begin
        pred_taken  = rd_hit && rd_e.ctr[1];
        pred_target = pred_taken ? rd_e.target : (pc_q + PC_W'(4));
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (up_e.ctr),
        .taken_i (upd_taken),
        .ctr_o   (up_ctr_nxt)
    );

    // Build the entry write: train on hit, allocate on taken miss, ignore not-taken miss.
    always_comb begin
        wr_en = 1'b0;
        wr_e  = up_e;
        if (upd_valid) begin
            if (up_hit) begin
                wr_en    = 1'b1;
                wr_e.ctr = up_ctr_nxt;
                if (upd_taken) begin
                    wr_e.target = upd_target;
                end
            end else if (upd_taken) begin
                wr_en       = 1'b1;
                wr_e.valid  = 1'b1;
                wr_e.tag    = up_tag;
                wr_e.target = upd_target;
                wr_e.ctr    = CTR_WEAK_T;
            end
        end
    end

    // Next fetch PC: redirect beats advance beats hold.
    always_comb begin
        pc_d = pc_q;
        if (redir_valid) begin
            pc_d = redir_pc;
        end else if (pcEN) begin
            pc_d = pred_target;
        end
    end

    // PC register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_INIT;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB array; reset clears valids and parks counters at weakly-not-taken.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
        end else if (wr_en) begin
            btb_q[up_idx] <= wr_e;
        end
    end

endmodule
